// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes the MIPS-32 instruction in ID, forwards operands,
// detects load-use hazards and registers the ALU operand/op bundle for EX.
module alu_issue_stage #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DWIDTH-1:0] id_rs_data,
  input  logic [DWIDTH-1:0] id_rt_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              exm_wen,
  input  logic [4:0]        exm_rd,
  input  logic [DWIDTH-1:0] exm_data,
  input  logic              wb_wen,
  input  logic [4:0]        wb_rd,
  input  logic [DWIDTH-1:0] wb_data,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic [DWIDTH-1:0] ex_rs1,
  output logic [DWIDTH-1:0] ex_rs2,
  output logic [DWIDTH-1:0] ex_store_data,
  output logic [4:0]        ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_ovf_chk,
  output logic              ex_illegal,
  output logic              hazard_stall
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1001;
  localparam logic [3:0] OP_SRL = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SRA = 4'b1101;
  localparam logic [3:0] OP_LUI = 4'b1110;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  function automatic logic [DWIDTH-1:0] sext16(input logic [15:0] v);
    return {{(DWIDTH-16){v[15]}}, v};
  endfunction

  function automatic logic [DWIDTH-1:0] zext16(input logic [15:0] v);
    return {{(DWIDTH-16){1'b0}}, v};
  endfunction

  // Youngest producer wins; $0 is hardwired to zero regardless of any writeback.
  function automatic logic [DWIDTH-1:0] fwd(
    input logic [4:0]        src,
    input logic [DWIDTH-1:0] regval,
    input logic              e_wen,
    input logic [4:0]        e_rd,
    input logic [DWIDTH-1:0] e_data,
    input logic              w_wen,
    input logic [4:0]        w_rd,
    input logic [DWIDTH-1:0] w_data
  );
    if (src == 5'd0)                    return '0;
    else if (e_wen && (e_rd == src))    return e_data;
    else if (w_wen && (w_rd == src))    return w_data;
    else                                return regval;
  endfunction

  logic [5:0]        opcode_p0;
  logic [5:0]        funct_p0;
  logic [4:0]        rs_p0, rt_p0, rdf_p0, shamt_p0;
  logic [15:0]       imm_p0;
  logic [DWIDTH-1:0] rs_fwd_p0, rt_fwd_p0;

  assign opcode_p0 = id_instr[31:26];
  assign rs_p0     = id_instr[25:21];
  assign rt_p0     = id_instr[20:16];
  assign rdf_p0    = id_instr[15:11];
  assign shamt_p0  = id_instr[10:6];
  assign funct_p0  = id_instr[5:0];
  assign imm_p0    = id_instr[15:0];

  assign rs_fwd_p0 = fwd(rs_p0, id_rs_data, exm_wen, exm_rd, exm_data, wb_wen, wb_rd, wb_data);
  assign rt_fwd_p0 = fwd(rt_p0, id_rt_data, exm_wen, exm_rd, exm_data, wb_wen, wb_rd, wb_data);

  logic [3:0]        op_p0;
  logic [DWIDTH-1:0] rs1_p0, rs2_p0;
  logic [4:0]        rd_p0;
  logic              wr_p0, mem_read_p0, mem_write_p0, branch_p0, ovf_p0, illegal_p0;
  logic              rs_used_p0, rt_used_p0;

  // ---- ID: decode and operand selection ----
  always_comb begin
    op_p0        = OP_AND;
    rs1_p0       = '0;
    rs2_p0       = '0;
    rd_p0        = 5'd0;
    wr_p0        = 1'b0;
    mem_read_p0  = 1'b0;
    mem_write_p0 = 1'b0;
    branch_p0    = 1'b0;
    ovf_p0       = 1'b0;
    illegal_p0   = 1'b0;
    rs_used_p0   = 1'b0;
    rt_used_p0   = 1'b0;
    case (opcode_p0)
      OPC_RTYPE: begin
        case (funct_p0)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_NOR, FN_SLT: begin
            rs1_p0     = rs_fwd_p0;
            rs2_p0     = rt_fwd_p0;
            rd_p0      = rdf_p0;
            wr_p0      = 1'b1;
            rs_used_p0 = 1'b1;
            rt_used_p0 = 1'b1;
            ovf_p0     = (funct_p0 == FN_ADD) || (funct_p0 == FN_SUB);
            case (funct_p0)
              FN_ADD, FN_ADDU: op_p0 = OP_ADD;
              FN_SUB, FN_SUBU: op_p0 = OP_SUB;
              FN_OR:           op_p0 = OP_OR;
              FN_NOR:          op_p0 = OP_NOR;
              FN_SLT:          op_p0 = OP_SLT;
              default:         op_p0 = OP_AND;
            endcase
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            rs1_p0     = rt_fwd_p0;
            rs2_p0     = {{(DWIDTH-5){1'b0}}, shamt_p0};
            rd_p0      = rdf_p0;
            wr_p0      = 1'b1;
            rt_used_p0 = 1'b1;
            case (funct_p0)
              FN_SRL:  op_p0 = OP_SRL;
              FN_SRA:  op_p0 = OP_SRA;
              default: op_p0 = OP_SLL;
            endcase
          end
          default: illegal_p0 = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_LUI: begin
        rs1_p0     = rs_fwd_p0;
        rd_p0      = rt_p0;
        wr_p0      = 1'b1;
        rs_used_p0 = 1'b1;
        case (opcode_p0)
          OPC_ADDI:  begin op_p0 = OP_ADD; rs2_p0 = sext16(imm_p0); ovf_p0 = 1'b1; end
          OPC_ADDIU: begin op_p0 = OP_ADD; rs2_p0 = sext16(imm_p0); end
          OPC_SLTI:  begin op_p0 = OP_SLT; rs2_p0 = sext16(imm_p0); end
          OPC_ANDI:  begin op_p0 = OP_AND; rs2_p0 = zext16(imm_p0); end
          OPC_ORI:   begin op_p0 = OP_OR;  rs2_p0 = zext16(imm_p0); end
          default:   begin op_p0 = OP_LUI; rs2_p0 = zext16(imm_p0); end
        endcase
      end
      OPC_LW: begin
        op_p0       = OP_ADD;
        rs1_p0      = rs_fwd_p0;
        rs2_p0      = sext16(imm_p0);
        rd_p0       = rt_p0;
        wr_p0       = 1'b1;
        mem_read_p0 = 1'b1;
        rs_used_p0  = 1'b1;
      end
      OPC_SW: begin
        op_p0        = OP_ADD;
        rs1_p0       = rs_fwd_p0;
        rs2_p0       = sext16(imm_p0);
        mem_write_p0 = 1'b1;
        rs_used_p0   = 1'b1;
        rt_used_p0   = 1'b1;
      end
      OPC_BEQ: begin
        op_p0      = OP_SUB;
        rs1_p0     = rs_fwd_p0;
        rs2_p0     = rt_fwd_p0;
        branch_p0  = 1'b1;
        rs_used_p0 = 1'b1;
        rt_used_p0 = 1'b1;
      end
      default: illegal_p0 = 1'b1;
    endcase
  end

  // The load result is not available until MEM, so a dependent instruction waits one cycle.
  assign hazard_stall = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                        ((rs_used_p0 && (ex_rd == rs_p0)) || (rt_used_p0 && (ex_rd == rt_p0)));

  logic bubble_p0;
  assign bubble_p0 = flush || (!stall && (hazard_stall || !id_valid));

  // ---- ID/EX register ----
  always_ff @(posedge clk) begin
    if (rst || bubble_p0) begin
      ex_valid      <= 1'b0;
      ex_op         <= OP_AND;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_store_data <= '0;
      ex_rd         <= 5'd0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_branch     <= 1'b0;
      ex_ovf_chk    <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= 1'b1;
      ex_op         <= op_p0;
      ex_rs1        <= rs1_p0;
      ex_rs2        <= rs2_p0;
      ex_store_data <= rt_fwd_p0;
      ex_rd         <= rd_p0;
      ex_reg_write  <= wr_p0 && (rd_p0 != 5'd0);
      ex_mem_read   <= mem_read_p0;
      ex_mem_write  <= mem_write_p0;
      ex_branch     <= branch_p0;
      ex_ovf_chk    <= ovf_p0;
      ex_illegal    <= illegal_p0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: hand-encoded instructions with hand-computed results.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_instr, id_rs_data, id_rt_data;
  logic        exm_wen, wb_wen;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_data, wb_data;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic        ex_ovf_chk, ex_illegal, hazard_stall;
  logic [3:0]  ex_op;
  logic [31:0] ex_rs1, ex_rs2, ex_store_data;
  logic [4:0]  ex_rd;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .stall(stall), .flush(flush),
    .exm_wen(exm_wen), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_ovf_chk(ex_ovf_chk), .ex_illegal(ex_illegal), .hazard_stall(hazard_stall)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; id_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    id_instr = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    id_rs_data = 32'd5; id_rt_data = 32'd7;
    exm_wen = 1'b0; exm_rd = 5'd0; exm_data = '0;
    wb_wen = 1'b0; wb_rd = 5'd0; wb_data = '0;

    // Reset held two cycles with a live instruction in ID
    tick(); tick();
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_op", {28'd0, ex_op}, 32'd0);
    chk("rst_rs1", ex_rs1, 32'd0);
    chk("rst_regwr", {31'd0, ex_reg_write}, 32'd0);
    chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);

    // add $3,$1,$2
    rst = 1'b0;
    tick();
    chk("add_valid", {31'd0, ex_valid}, 32'd1);
    chk("add_op", {28'd0, ex_op}, 32'h2);
    chk("add_rs1", ex_rs1, 32'd5);
    chk("add_rs2", ex_rs2, 32'd7);
    chk("add_rd", {27'd0, ex_rd}, 32'd3);
    chk("add_regwr", {31'd0, ex_reg_write}, 32'd1);
    chk("add_ovf", {31'd0, ex_ovf_chk}, 32'd1);

    // Forwarding priority: exm beats wb
    exm_wen = 1'b1; exm_rd = 5'd1; exm_data = 32'hA;
    wb_wen = 1'b1; wb_rd = 5'd1; wb_data = 32'hB;
    tick();
    chk("fwd_exm_rs1", ex_rs1, 32'hA);
    chk("fwd_exm_rs2", ex_rs2, 32'd7);
    exm_rd = 5'd0; wb_rd = 5'd2;
    tick();
    chk("fwd_wb_rs1", ex_rs1, 32'd5);
    chk("fwd_wb_rs2", ex_rs2, 32'hB);
    wb_rd = 5'd0;
    tick();
    chk("fwd_zero_rs1", ex_rs1, 32'd5);
    chk("fwd_zero_rs2", ex_rs2, 32'd7);
    exm_wen = 1'b0; wb_wen = 1'b0;

    // lw $4,8($1) followed by dependent add $5,$4,$2
    id_instr = itype(6'h23, 5'd1, 5'd4, 16'd8);
    tick();
    chk("lw_rs2", ex_rs2, 32'd8);
    chk("lw_rd", {27'd0, ex_rd}, 32'd4);
    chk("lw_memrd", {31'd0, ex_mem_read}, 32'd1);
    chk("lw_ovf", {31'd0, ex_ovf_chk}, 32'd0);
    id_instr = rtype(5'd4, 5'd2, 5'd5, 5'd0, 6'h20);
    id_rs_data = 32'd99;
    #1;
    chk("lu_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_memrd", {31'd0, ex_mem_read}, 32'd0);
    chk("lu_hazard_clear", {31'd0, hazard_stall}, 32'd0);
    exm_wen = 1'b1; exm_rd = 5'd4; exm_data = 32'h1234;
    tick();
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_add_rs1", ex_rs1, 32'h1234);
    chk("lu_add_rd", {27'd0, ex_rd}, 32'd5);
    exm_wen = 1'b0; exm_rd = 5'd0; id_rs_data = 32'd5;

    // sra $6,$7,3
    id_instr = rtype(5'd0, 5'd7, 5'd6, 5'd3, 6'h03);
    id_rt_data = 32'h8000_0000;
    tick();
    chk("sra_op", {28'd0, ex_op}, 32'hD);
    chk("sra_rs1", ex_rs1, 32'h8000_0000);
    chk("sra_rs2", ex_rs2, 32'd3);
    chk("sra_rd", {27'd0, ex_rd}, 32'd6);
    id_rt_data = 32'd7;

    // lui $8,0x1234
    id_instr = itype(6'h0F, 5'd0, 5'd8, 16'h1234);
    tick();
    chk("lui_op", {28'd0, ex_op}, 32'hE);
    chk("lui_rs2", ex_rs2, 32'h0000_1234);
    chk("lui_rd", {27'd0, ex_rd}, 32'd8);

    // andi $9,$1,0xFFFF
    id_instr = itype(6'h0C, 5'd1, 5'd9, 16'hFFFF);
    tick();
    chk("andi_op", {28'd0, ex_op}, 32'h0);
    chk("andi_rs2", ex_rs2, 32'h0000_FFFF);

    // addi $10,$1,-1
    id_instr = itype(6'h08, 5'd1, 5'd10, 16'hFFFF);
    tick();
    chk("addi_rs2", ex_rs2, 32'hFFFF_FFFF);
    chk("addi_ovf", {31'd0, ex_ovf_chk}, 32'd1);

    // Hold for three cycles while ID changes underneath
    stall = 1'b1;
    id_instr = itype(6'h2B, 5'd1, 5'd2, 16'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rd", {27'd0, ex_rd}, 32'd10);
      chk("stall_rs2", ex_rs2, 32'hFFFF_FFFF);
    end
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_regwr", {31'd0, ex_reg_write}, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // sw $2,4($1)
    tick();
    chk("sw_memwr", {31'd0, ex_mem_write}, 32'd1);
    chk("sw_regwr", {31'd0, ex_reg_write}, 32'd0);
    chk("sw_store", ex_store_data, 32'd7);
    chk("sw_rs2", ex_rs2, 32'd4);

    // beq $1,$2
    id_instr = itype(6'h04, 5'd1, 5'd2, 16'd16);
    tick();
    chk("beq_op", {28'd0, ex_op}, 32'h6);
    chk("beq_branch", {31'd0, ex_branch}, 32'd1);
    chk("beq_regwr", {31'd0, ex_reg_write}, 32'd0);

    // Illegal opcode 0x3F
    id_instr = 32'hFC00_0000;
    tick();
    chk("ill_valid", {31'd0, ex_valid}, 32'd1);
    chk("ill_flag", {31'd0, ex_illegal}, 32'd1);
    chk("ill_regwr", {31'd0, ex_reg_write}, 32'd0);
    chk("ill_memrd", {31'd0, ex_mem_read}, 32'd0);

    // addu $0,$1,$2 never writes
    id_instr = rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h21);
    tick();
    chk("addu0_valid", {31'd0, ex_valid}, 32'd1);
    chk("addu0_regwr", {31'd0, ex_reg_write}, 32'd0);
    chk("addu0_ovf", {31'd0, ex_ovf_chk}, 32'd0);

    // id_valid=0 loads a bubble
    id_valid = 1'b0;
    tick();
    chk("novalid_valid", {31'd0, ex_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
